// File: rtl/pc_sel_pkg.sv
// Shared constants and helpers for the PC select unit.
// The constants are the select code offsets relative to NUM_SRC, plus the default vectors.
package pc_sel_pkg;

   localparam int unsigned SEL_VEC_A_OFS = 0;
   localparam int unsigned SEL_VEC_B_OFS = 1;
   localparam int unsigned SEL_RET_OFS   = 2;

   localparam int unsigned DEFAULT_VEC_A = 22;
   localparam int unsigned DEFAULT_VEC_B = 12;

   // Codes above the RET code do not name a target.
   function automatic logic bad_sel(input int unsigned sel, input int unsigned num_src);
      return sel > (num_src + SEL_RET_OFS);
   endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with push, pop and replace-top.
// When the stack is full, a push overwrites the oldest entry and sets a sticky overflow flag.
module return_addr_stack
   import pc_sel_pkg::*;
#(
   parameter int unsigned WIDTH     = 17,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             ovf
);

   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]    tp, tp_inc, tp_dec, tp_nxt, wr_idx;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             wr, ovf_nxt, pop_ok;

   assign pop_ok = pop & ~empty;
   assign tp_inc = (tp == PW'(RAS_DEPTH - 1)) ? '0 : tp + PW'(1);
   assign tp_dec = (tp == '0) ? PW'(RAS_DEPTH - 1) : tp - PW'(1);
   assign top    = mem[tp];

   // A push together with a pop rewrites the top slot in place.
   always_comb begin
      tp_nxt  = tp;
      cnt_nxt = cnt;
      wr      = 1'b0;
      wr_idx  = tp;
      ovf_nxt = ovf;
      if (push && pop_ok) begin
         wr = 1'b1;
      end else if (push) begin
         wr     = 1'b1;
         wr_idx = tp_inc;
         tp_nxt = tp_inc;
         if (cnt == CW'(RAS_DEPTH)) ovf_nxt = 1'b1;
         else                       cnt_nxt = cnt + CW'(1);
      end else if (pop_ok) begin
         tp_nxt  = tp_dec;
         cnt_nxt = cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tp    <= '0;
         cnt   <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         tp    <= tp_nxt;
         cnt   <= cnt_nxt;
         empty <= (cnt_nxt == '0);
         full  <= (cnt_nxt == CW'(RAS_DEPTH));
         ovf   <= ovf_nxt;
      end
   end

   // Storage has no reset, so its contents are undefined until written.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_idx] <= wdata;
   end

endmodule

// File: rtl/pc_select_unit.sv
// Program-counter register with next-PC select mux, RAS call/return and error pulse.
module pc_select_unit
   import pc_sel_pkg::*;
#(
   parameter int unsigned WIDTH     = 17,
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned SEL_W     = 4,
   parameter int unsigned VEC_A     = DEFAULT_VEC_A,
   parameter int unsigned VEC_B     = DEFAULT_VEC_B,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic [NUM_SRC*WIDTH-1:0] src,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     push,
   output logic [WIDTH-1:0]         pc,
   output logic [WIDTH-1:0]         pc_next,
   output logic                     ras_empty,
   output logic                     ras_full,
   output logic                     err,
   output logic                     ras_ovf
);

   logic [WIDTH-1:0] pc_plus1, ras_top;
   logic             err_c, pop_c;

   assign pc_plus1 = pc + WIDTH'(1);

   // Next-PC select; RET on an empty stack falls back to vector A.
   always_comb begin
      pc_next = pc_plus1;
      err_c   = 1'b0;
      pop_c   = 1'b0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (sel == SEL_W'(i)) pc_next = src[i*WIDTH +: WIDTH];
      end
      if (sel == SEL_W'(NUM_SRC + SEL_VEC_A_OFS)) begin
         pc_next = WIDTH'(VEC_A);
      end else if (sel == SEL_W'(NUM_SRC + SEL_VEC_B_OFS)) begin
         pc_next = WIDTH'(VEC_B);
      end else if (sel == SEL_W'(NUM_SRC + SEL_RET_OFS)) begin
         if (ras_empty) begin
            pc_next = WIDTH'(VEC_A);
            err_c   = 1'b1;
         end else begin
            pc_next = ras_top;
            pop_c   = 1'b1;
         end
      end
      if (bad_sel(32'(sel), NUM_SRC)) err_c = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc  <= WIDTH'(RESET_PC);
         err <= 1'b0;
      end else begin
         err <= err_c & ~stall;
         if (!stall) pc <= pc_next;
      end
   end

   return_addr_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (push & ~stall),
      .pop   (pop_c & ~stall),
      .wdata (pc_plus1),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full),
      .ovf   (ras_ovf)
   );

endmodule

// File: tb/tb_pc_select_unit.sv
// Directed bench for pc_select_unit: queue-based reference model plus literal spot checks.
module tb_pc_select_unit;

   localparam int unsigned W     = 17;
   localparam int unsigned NS    = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned VA    = 22;
   localparam int unsigned VB    = 12;
   localparam int unsigned RET   = NS + 2;
   localparam int unsigned MASK  = (1 << W) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            stall;
   logic [NS*W-1:0] src;
   logic [3:0]      sel;
   logic            push;
   logic [W-1:0]    pc, pc_next;
   logic            ras_empty, ras_full, err, ras_ovf;

   int checks   = 0;
   int failures = 0;

   int unsigned m_pc;
   int unsigned q[$];
   bit          m_err, m_ovf;

   pc_select_unit #(
      .WIDTH(W), .NUM_SRC(NS), .SEL_W(4), .VEC_A(VA), .VEC_B(VB),
      .RESET_PC(0), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .src(src), .sel(sel), .push(push),
      .pc(pc), .pc_next(pc_next), .ras_empty(ras_empty), .ras_full(ras_full),
      .err(err), .ras_ovf(ras_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // What the next PC must be under the select rules, from model state.
   function automatic void model_next(input int unsigned s, output int unsigned nx, output bit bd);
      bd = 1'b0;
      nx = (m_pc + 1) & MASK;
      if (s < NS)              nx = int'(src[s*W +: W]);
      else if (s == NS)        nx = VA & MASK;
      else if (s == NS + 1)    nx = VB & MASK;
      else if (s == RET) begin
         if (q.size() == 0) begin nx = VA & MASK; bd = 1'b1; end
         else               nx = q[$];
      end else               bd = 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      int unsigned nx;
      bit          bd;
      if (rst) begin
         m_pc = 0; q.delete(); m_err = 1'b0; m_ovf = 1'b0;
      end else if (stall) begin
         m_err = 1'b0;
      end else begin
         model_next(32'(sel), nx, bd);
         if (sel == 4'(RET) && q.size() > 0) void'(q.pop_back());
         if (push) begin
            if (q.size() == DEPTH) begin q.delete(0); m_ovf = 1'b1; end
            q.push_back((m_pc + 1) & MASK);
         end
         m_pc  = nx;
         m_err = bd;
      end
   end

   always @(negedge clk) begin : compare
      int unsigned nx;
      bit          bd;
      if (!rst) begin
         model_next(32'(sel), nx, bd);
         chk("pc_next", 32'(pc_next), nx);
         chk("pc", 32'(pc), m_pc);
         chk("ras_empty", 32'(ras_empty), 32'(q.size() == 0));
         chk("ras_full", 32'(ras_full), 32'(q.size() == DEPTH));
         chk("err", 32'(err), 32'(m_err));
         chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
      end
   end

   task automatic set_src(input int unsigned a, b, c, d);
      src = {W'(d), W'(c), W'(b), W'(a)};
   endtask

   task automatic tick(input int unsigned s, input bit p, input bit st);
      @(negedge clk);
      #1;
      sel = 4'(s); push = p; stall = st;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; sel = '0; push = 1'b0;
      set_src(32'h100, 32'h1FFFF, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_empty", 32'(ras_empty), 1);
      chk("rst_full", 32'(ras_full), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_ovf", 32'(ras_ovf), 0);
      #1 rst = 1'b0;

      tick(0, 0, 0); chk("src0_a", 32'(pc), 32'h100); chk("src0_err", 32'(err), 0);
      tick(0, 0, 0); chk("src0_b", 32'(pc), 32'h100);
      tick(4, 0, 0); chk("vec_a", 32'(pc), 22);
      tick(5, 0, 0); chk("vec_b", 32'(pc), 12);
      tick(1, 0, 0); chk("src1_max", 32'(pc), 32'h1FFFF);
      tick(15, 0, 0); chk("wrap_pc", 32'(pc), 0); chk("bad_err", 32'(err), 1);
      tick(0, 0, 0); chk("err_clear", 32'(err), 0);

      set_src(5, 9, 13, 13);
      tick(0, 0, 0); chk("pc5", 32'(pc), 5);
      tick(1, 1, 0);
      tick(2, 1, 0);
      tick(3, 1, 0); chk("pushed3_empty", 32'(ras_empty), 0);
      tick(RET, 0, 0); chk("ret14", 32'(pc), 14);
      tick(RET, 0, 0); chk("ret10", 32'(pc), 10);
      tick(RET, 0, 0); chk("ret6", 32'(pc), 6); chk("ret_empty", 32'(ras_empty), 1);
      tick(RET, 0, 0); chk("under_pc", 32'(pc), 22); chk("under_err", 32'(err), 1);

      set_src(5, 9, 13, 32'h30);
      tick(0, 1, 0);
      tick(1, 1, 0);
      tick(2, 1, 0);
      tick(3, 1, 0); chk("full4", 32'(ras_full), 1); chk("noovf4", 32'(ras_ovf), 0);
      tick(5, 1, 0); chk("full5", 32'(ras_full), 1); chk("ovf5", 32'(ras_ovf), 1);
      tick(RET, 0, 0); chk("lifo0", 32'(pc), 32'h31);
      tick(RET, 0, 0); chk("lifo1", 32'(pc), 14);
      tick(RET, 0, 0); chk("lifo2", 32'(pc), 10);
      tick(RET, 0, 0); chk("lifo3", 32'(pc), 6); chk("lifo_empty", 32'(ras_empty), 1);
      chk("lifo_err", 32'(err), 0);

      set_src(32'h3F, 32'h20, 0, 0);
      tick(0, 0, 0);
      tick(1, 1, 0); chk("pc20", 32'(pc), 32'h20);
      tick(RET, 1, 0); chk("pr_pc", 32'(pc), 32'h40); chk("pr_cnt", 32'(ras_empty), 0);
      tick(RET, 0, 0); chk("pr_top", 32'(pc), 32'h21); chk("pr_empty", 32'(ras_empty), 1);

      tick(4, 1, 1); chk("stall_pc", 32'(pc), 32'h21); chk("stall_err", 32'(err), 0);
      chk("stall_empty", 32'(ras_empty), 1);
      tick(9, 0, 1); chk("stall_bad_err", 32'(err), 0); chk("ovf_sticky", 32'(ras_ovf), 1);

      #3;
      rst = 1'b1; sel = '0; push = 1'b0; stall = 1'b0;
      #1;
      chk("arst_pc", 32'(pc), 0);
      chk("arst_ovf", 32'(ras_ovf), 0);
      chk("arst_empty", 32'(ras_empty), 1);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_pc", 32'(pc), 32'h3F);
      tick(5, 0, 0); chk("post_rst_vecb", 32'(pc), 12);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
